// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the four-channel TDM demultiplexer.
package tdm_demux_pkg;

  localparam int unsigned SLOTS = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit slot index counter: clear (or reset) beats load-to-1, which beats increment.
module tdm_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  load,
  input  logic  en,
  output slot_t count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= slot_t'(1);
    end else if (en) begin
      count <= count + slot_t'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of a 4-to-1 TDM link: locks to the slot-0 frame marker and presents
// all four channels with a one-cycle valid pulse. Optional TDM_DEMUX4_ERR_CNT_EN adds
// a saturating framing-error counter output.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_G_n,
  input  logic             i_frame,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_Y0,
  output logic [WIDTH-1:0] o_Y1,
  output logic [WIDTH-1:0] o_Y2,
  output logic [WIDTH-1:0] o_Y3,
  output logic             o_valid,
  output logic [1:0]       o_slot,
  output logic             o_lock,
  output logic             o_sync_err
`ifdef TDM_DEMUX4_ERR_CNT_EN
  ,
  output logic [7:0]       o_err_cnt
`endif
);

  state_t           state;
  logic [WIDTH-1:0] shadow0, shadow1, shadow2;
  logic             en_cyc;
  logic             framing_err;
  logic             ctr_clr, ctr_load, ctr_inc;

  assign en_cyc = ~i_G_n;
  assign o_lock = (state == LOCK);

  // Missing marker at slot 0 or an early marker anywhere else.
  assign framing_err = en_cyc && (state == LOCK) &&
                       (i_frame ? (o_slot != '0) : (o_slot == '0));

  always_comb begin
    ctr_clr  = 1'b0;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
    if (en_cyc) begin
      if (i_frame) begin
        ctr_load = 1'b1;
      end else if (state == HUNT || o_slot == '0) begin
        ctr_clr = 1'b1;
      end else begin
        ctr_inc = 1'b1;
      end
    end
  end

  tdm_slot_ctr u_slot_ctr (
    .clk   (i_clk),
    .rst   (i_rst),
    .clr   (ctr_clr),
    .load  (ctr_load),
    .en    (ctr_inc),
    .count (o_slot)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= HUNT;
      shadow0    <= '0;
      shadow1    <= '0;
      shadow2    <= '0;
      o_Y0       <= '0;
      o_Y1       <= '0;
      o_Y2       <= '0;
      o_Y3       <= '0;
      o_valid    <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_sync_err <= framing_err;
      if (en_cyc) begin
        unique case (state)
          HUNT: begin
            if (i_frame) begin
              shadow0 <= i_data;
              state   <= LOCK;
            end
          end
          LOCK: begin
            // A marker always restarts the frame, so an early one simply overwrites slot 0.
            if (i_frame) begin
              shadow0 <= i_data;
            end else if (o_slot == '0) begin
              state <= HUNT;
            end else if (o_slot == slot_t'(1)) begin
              shadow1 <= i_data;
            end else if (o_slot == slot_t'(2)) begin
              shadow2 <= i_data;
            end else begin
              o_Y0    <= shadow0;
              o_Y1    <= shadow1;
              o_Y2    <= shadow2;
              o_Y3    <= i_data;
              o_valid <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef TDM_DEMUX4_ERR_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_cnt <= '0;
    end else if (framing_err && o_err_cnt != 8'hFF) begin
      o_err_cnt <= o_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 (WIDTH=4): directed test-plan frames then random traffic.
module tb_tdm_demux4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         g_n = 1'b1;
  logic         frame = 1'b0;
  logic [W-1:0] data = '0;
  logic [W-1:0] y0, y1, y2, y3;
  logic         valid, lock, sync_err;
  logic [1:0]   slot;
`ifdef TDM_DEMUX4_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  tdm_demux4 #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_G_n      (g_n),
    .i_frame    (frame),
    .i_data     (data),
    .o_Y0       (y0),
    .o_Y1       (y1),
    .o_Y2       (y2),
    .o_Y3       (y3),
    .o_valid    (valid),
    .o_slot     (slot),
    .o_lock     (lock),
    .o_sync_err (sync_err)
`ifdef TDM_DEMUX4_ERR_CNT_EN
    ,
    .o_err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic          err;
    logic          lock;
    logic [1:0]    slot;
    logic [4*W-1:0] y;
    logic [7:0]    cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: frame state as plain integers and arrays.
  bit           m_locked;
  int           m_next;
  logic [W-1:0] m_buf[3];
  logic [W-1:0] m_y[4];
  bit           m_valid, m_err;
  int           m_cnt;

  function automatic void model_reset();
    m_locked = 0; m_next = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    for (int i = 0; i < 3; i++) m_buf[i] = '0;
    for (int i = 0; i < 4; i++) m_y[i] = '0;
  endfunction

  function automatic void model_step(bit r, bit gn, bit f, logic [W-1:0] d);
    m_valid = 0;
    m_err   = 0;
    if (r) begin
      model_reset();
      return;
    end
    if (gn) return;
    if (!m_locked) begin
      if (f) begin m_buf[0] = d; m_next = 1; m_locked = 1; end
    end else if (f) begin
      if (m_next != 0) m_err = 1;
      m_buf[0] = d;
      m_next = 1;
    end else if (m_next == 0) begin
      m_err = 1;
      m_locked = 0;
    end else if (m_next < 3) begin
      m_buf[m_next] = d;
      m_next++;
    end else begin
      m_y[0] = m_buf[0]; m_y[1] = m_buf[1]; m_y[2] = m_buf[2]; m_y[3] = d;
      m_valid = 1;
      m_next = 0;
    end
    if (m_err && m_cnt < 255) m_cnt++;
  endfunction

  task automatic step(input bit r, input bit gn, input bit f, input logic [W-1:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; g_n = gn; frame = f; data = d;
    model_step(r, gn, f, d);
    e.valid = m_valid;
    e.err   = m_err;
    e.lock  = m_locked;
    e.slot  = 2'(m_next);
    e.y     = {m_y[3], m_y[2], m_y[1], m_y[0]};
    e.cnt   = 8'(m_cnt);
    q.push_back(e);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    logic [7:0] cnt_act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
`ifdef TDM_DEMUX4_ERR_CNT_EN
        cnt_act = err_cnt;
`else
        cnt_act = e.cnt;
`endif
        checks++;
        if (valid !== e.valid || sync_err !== e.err || lock !== e.lock || slot !== e.slot ||
            {y3, y2, y1, y0} !== e.y || cnt_act !== e.cnt) begin
          failures++;
          $display("FAIL cycle t=%0t got valid=%b err=%b lock=%b slot=%0d y=%h cnt=%0d expected valid=%b err=%b lock=%b slot=%0d y=%h cnt=%0d",
                   $time, valid, sync_err, lock, slot, {y3, y2, y1, y0}, cnt_act,
                   e.valid, e.err, e.lock, e.slot, e.y, e.cnt);
        end
      end
    end
  end

  // Directed check against test-plan constants, taken after the most recent edge.
  task automatic check_out(input string name, input bit v, input bit er, input bit lk,
                           input logic [1:0] sl, input logic [4*W-1:0] yv);
    @(posedge clk);
    #2;
    checks++;
    if (valid !== v || sync_err !== er || lock !== lk || slot !== sl || {y3, y2, y1, y0} !== yv) begin
      failures++;
      $display("FAIL %s got valid=%b err=%b lock=%b slot=%0d y=%h expected valid=%b err=%b lock=%b slot=%0d y=%h",
               name, valid, sync_err, lock, slot, {y3, y2, y1, y0}, v, er, lk, sl, yv);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset then idle.
    step(1, 1, 0, 4'h0);
    step(1, 0, 1, 4'h9);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 4'h0);
    check_out("reset_idle", 0, 0, 0, 2'd0, 16'h0000);

    // Clean frame.
    step(0, 0, 1, 4'hA); step(0, 0, 0, 4'h5); step(0, 0, 0, 4'hC); step(0, 0, 0, 4'h3);
    check_out("clean_frame", 1, 0, 1, 2'd0, 16'h3C5A);

    // Stalled frame with noise on disabled cycles.
    step(0, 0, 1, 4'hA); step(0, 0, 0, 4'h5);
    step(0, 1, 1, 4'hF); step(0, 1, 1, 4'hF);
    check_out("stall_hold", 0, 0, 1, 2'd2, 16'h3C5A);
    step(0, 0, 0, 4'hC); step(0, 0, 0, 4'h3);
    check_out("stall_frame", 1, 0, 1, 2'd0, 16'h3C5A);

    // Early marker at slot 2.
    step(0, 0, 1, 4'h9); step(0, 0, 0, 4'h8); step(0, 0, 1, 4'h7);
    check_out("early_marker", 0, 1, 1, 2'd1, 16'h3C5A);
    step(0, 0, 0, 4'h1); step(0, 0, 0, 4'h2); step(0, 0, 0, 4'h4);
    check_out("early_frame", 1, 0, 1, 2'd0, 16'h4217);

    // Missing marker at slot 0, then relock.
    step(0, 0, 0, 4'h6);
    check_out("missing_marker", 0, 1, 0, 2'd0, 16'h4217);
    step(0, 0, 1, 4'hB); step(0, 0, 0, 4'hC); step(0, 0, 0, 4'hD); step(0, 0, 0, 4'hE);
    check_out("relock_frame", 1, 0, 1, 2'd0, 16'hEDCB);

    // Reset mid-frame.
    step(0, 0, 1, 4'h1); step(0, 0, 0, 4'h2); step(1, 0, 0, 4'h3);
    check_out("reset_midframe", 0, 0, 0, 2'd0, 16'h0000);
    step(0, 0, 0, 4'h4);
    check_out("hunt_after_reset", 0, 0, 0, 2'd0, 16'h0000);

    // Random traffic, mostly well-formed frames with occasional faults and stalls.
    for (int i = 0; i < 3000; i++) begin
      bit r, gn, f;
      r  = ($urandom_range(0, 199) == 0);
      gn = ($urandom_range(0, 3) == 0);
      if (m_next == 0) f = ($urandom_range(0, 9) != 0);
      else             f = ($urandom_range(0, 19) == 0);
      if (gn) f = ($urandom_range(0, 1) == 1);
      step(r, gn, f, W'($urandom));
    end

    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'h0);
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of a 4-to-1 multiplexed link. A transmitter steps a dual-select (B,A) through inputs C0..C3 onto one data line and marks slot 0 with a frame pulse. This block locks to that frame pulse, tracks the slot index, and captures each slot into its channel. It presents all four channels together as registered outputs with a one-cycle valid pulse per complete frame.

## Interface
- `WIDTH`, default 1: bits per slot sample.
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_G_n`  in  1  strobe, active low. When high, the cycle is ignored.
- `i_frame`  in  1  frame marker. High with the slot-0 sample.
- `i_data`  in  WIDTH  multiplexed sample for the current slot.
- `o_Y0`..`o_Y3`  out  WIDTH each  demultiplexed channel words.
- `o_valid`  out  1  one-cycle pulse: `o_Y0`..`o_Y3` were just updated.
- `o_slot`  out  2  index of the next expected slot, as {B,A}.
- `o_lock`  out  1  high while in state LOCK.
- `o_sync_err`  out  1  one-cycle pulse on a framing violation.

## Operation
- States:
  - HUNT: the reset state.
  - LOCK.
- Enabled cycle: an edge with `i_G_n`=0. A disabled edge changes no state, no counter and no data, and `o_valid`/`o_sync_err` are 0.
- HUNT:
  - `i_frame`=1 on an enabled cycle: capture `i_data` as slot 0, set `o_slot`=1, go to LOCK.
  - Otherwise stay in HUNT with `o_slot`=0.
- LOCK, enabled cycle, `o_slot`=s:
  - s=0 with `i_frame`=1: capture slot 0, set `o_slot`=1.
  - s=0 with `i_frame`=0 (missing marker): pulse `o_sync_err`, discard the partial frame, go to HUNT, keep `o_slot`=0.
  - s≠0 with `i_frame`=1 (early marker): pulse `o_sync_err`, discard the partial frame, treat `i_data` as slot 0, set `o_slot`=1.
  - s=1 or 2 with `i_frame`=0: capture into shadow slot s, increment `o_slot`.
  - s=3 with `i_frame`=0: load `o_Y0`..`o_Y2` from the shadow registers and `o_Y3` from `i_data`, pulse `o_valid`, wrap `o_slot` to 0.
- `o_Yn` hold their value between valid pulses. A discarded frame never updates them.
- `o_slot` is a 2-bit counter that wraps 3→0. No other arithmetic.

## Timing
- Reset: state HUNT. All of the following are 0:
  - `o_Y0`..`o_Y3`
  - `o_valid`, `o_sync_err`, `o_lock`
  - `o_slot`
  - the shadow registers
- Reset takes priority over every input and discards any partial frame.
- Latency: `o_Yn` and `o_valid` are registered on the same edge that samples slot 3. They are visible in the following cycle, with 0 cycles of extra delay.
- Minimum frame is 4 enabled cycles. Disabled cycles may be interleaved anywhere (stall).
- `i_frame` on a disabled cycle is ignored.
- Back-to-back frames with no gap give `o_valid` exactly every 4th enabled cycle.
- `o_sync_err` and `o_valid` are never high in the same cycle.

## Configuration
- `TDM_DEMUX4_ERR_CNT_EN` defined:
  - Adds output `o_err_cnt` (out, 8 bits).
  - The counter increments on each `o_sync_err` pulse and saturates at 255.
  - It is cleared by `i_rst`.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `tdm_demux_pkg` holds:
  - State enum `{HUNT, LOCK}`.
  - `SLOTS`=4.
  - 2-bit slot index type.
- One sub-module, `tdm_slot_ctr`: a 2-bit counter with enable, synchronous load-to-1 and clear.
- Shadow registers, the output registers and the FSM stay in the top module.

## Test plan
Benches use WIDTH=4.
- **Reset:** reset, then idle with `i_G_n`=1 for 5 cycles → all outputs 0, `o_lock`=0.
- **Clean frame:** `i_G_n`=0, `i_frame` high with 4'hA, then 4'h5, 4'hC, 4'h3 → one `o_valid` pulse; `o_Y0..3`=A,5,C,3; `o_slot` returns to 0.
- **Stall:** same frame with `i_G_n`=1 for 2 cycles between slot 1 and slot 2, while `i_data`=4'hF and `i_frame`=1 → same outputs as the clean frame, no error.
- **Early marker:** `i_frame` reasserted at slot 2 with 4'h7, then 4'h1, 4'h2, 4'h4 → `o_sync_err` pulse; then `o_valid` with `o_Y0..3`=7,1,2,4.
- **Missing marker:**
  - After a valid frame, slot-0 sample arrives without `i_frame` → `o_sync_err`, `o_lock`=0, outputs unchanged.
  - A following marked frame relocks.
- **Reset mid-frame:** `i_rst` after slot 1 → HUNT; outputs cleared; no `o_valid`. With `TDM_DEMUX4_ERR_CNT_EN`, `o_err_cnt` also reads 0.
